// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: scoreboard sizing defaults and the
// per-instruction-class result latencies seen at the ID stage.
package pipeline_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_AW_DEF   = 5;
    localparam int MAX_LAT_DEF  = 4;
    localparam int LAT_W_DEF    = 3;
    localparam int CNT_W_DEF    = 32;

    // Cycles until a result reaches a forwarding point
    localparam logic [LAT_W_DEF-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W_DEF-1:0] LAT_LOAD = 3'd1;
    localparam logic [LAT_W_DEF-1:0] LAT_MUL  = 3'd3;

endpackage

// File: rtl/hazard_scoreboard_reg_countdown.sv
// One register's pending-result countdown: load on issue, otherwise
// count down to zero, hold everything while the pipeline is frozen.
module reg_countdown
    import pipeline_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             nz_o
);

    logic [LAT_W-1:0] cnt_r;

    // Countdown register; a new issue takes priority over the decrement
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= '0;
        end else if (hold_i) begin
            cnt_r <= cnt_r;
        end else if (load_i) begin
            cnt_r <= load_val_i;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - LAT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;
    assign nz_o  = (cnt_r != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register result countdowns drive the
// RAW/WAW stall decision, the PC / IF-ID write enables, the ID/EX bubble
// select and a saturating stall-cycle counter.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [REG_AW-1:0] issue_rs_i,
    input  logic [REG_AW-1:0] issue_rt_i,
    input  logic              issue_uses_rs_i,
    input  logic              issue_uses_rt_i,
    input  logic              issue_wr_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [LAT_W-1:0]  issue_lat_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              stall_o,
    output logic              pcwrite_o,
    output logic              ifidwrite_o,
    output logic              bubble_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    // Every encodable address gets a slot so indexing is always in range;
    // r0 and any slot beyond NUM_REGS read as permanently idle.
    localparam int NUM_SLOTS = 1 << REG_AW;

    logic [LAT_W-1:0]     cnt_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] nz_s;
    logic [LAT_W-1:0]     lat_eff_s;
    logic                 raw_s;
    logic                 waw_s;
    logic                 stall_s;
    logic                 accept_s;
    logic [CNT_W-1:0]     stall_cnt_r;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_reg
        if ((g >= 1) && (g < NUM_REGS)) begin : g_trk
            logic load_s;
            assign load_s = accept_s & issue_wr_i & (issue_rd_i == REG_AW'(g));
            reg_countdown #(.LAT_W(LAT_W)) u_cnt (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .hold_i     (freeze_i),
                .load_i     (load_s),
                .load_val_i (lat_eff_s),
                .cnt_o      (cnt_s[g]),
                .nz_o       (nz_s[g])
            );
        end else begin : g_zero
            assign cnt_s[g] = '0;
            assign nz_s[g]  = 1'b0;
        end
    end

    // Hazard decision: clamp latency, then RAW on sources and WAW on dest
    always_comb begin
        lat_eff_s = issue_lat_i;
        raw_s     = 1'b0;
        waw_s     = 1'b0;
        if (issue_lat_i > LAT_W'(MAX_LAT)) begin
            lat_eff_s = LAT_W'(MAX_LAT);
        end else begin
            lat_eff_s = issue_lat_i;
        end
        raw_s = issue_valid_i &
                ((issue_uses_rs_i & (issue_rs_i != '0) & nz_s[issue_rs_i]) |
                 (issue_uses_rt_i & (issue_rt_i != '0) & nz_s[issue_rt_i]));
        // An older, slower write still in flight must not land after ours
        waw_s = issue_valid_i & issue_wr_i & (issue_rd_i != '0) &
                (cnt_s[issue_rd_i] > lat_eff_s);
    end

    // A flushed instruction never stalls and never creates an entry
    assign stall_s  = (raw_s | waw_s) & ~flush_i;
    assign accept_s = issue_valid_i & ~stall_s & ~flush_i & ~freeze_i;

    // Stall performance counter: frozen cycles excluded, sticks at all-ones
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= '0;
        end else if (!freeze_i && stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_o       = stall_s;
    assign pcwrite_o     = ~stall_s;
    assign ifidwrite_o   = ~stall_s;
    assign bubble_o      = stall_s;
    assign busy_o        = |nz_s;
    assign stall_count_o = stall_cnt_r;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-load-use hazard detector in the 5-stage MIPS pipeline.
- Tracks the cycles remaining until each architectural register's pending result becomes forwardable. Latency is set per instruction: ALU 0, load 1, future multi-cycle mul/div up to MAX_LAT.
- Sits at ID. Drives the PC write enable, IF/ID write enable and control-bubble select, and keeps a stall performance counter.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- REG_AW, 5, register address width; must satisfy 2**REG_AW >= NUM_REGS.
- MAX_LAT, 4, largest accepted result latency in cycles.
- LAT_W, 3, width of latency fields and per-register counters; must hold MAX_LAT.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- issue_valid_i  input  1  ID holds a valid instruction.
- issue_rs_i  input  REG_AW  source register 1.
- issue_rt_i  input  REG_AW  source register 2.
- issue_uses_rs_i  input  1  instruction reads rs.
- issue_uses_rt_i  input  1  instruction reads rt.
- issue_wr_i  input  1  instruction writes a register.
- issue_rd_i  input  REG_AW  destination register.
- issue_lat_i  input  LAT_W  cycles until the result is forwardable.
- flush_i  input  1  ID instruction killed by branch/jump; never issues.
- freeze_i  input  1  whole pipeline frozen (memory wait).
- stall_o  output  1  issue blocked this cycle.
- pcwrite_o  output  1  equals ~stall_o.
- ifidwrite_o  output  1  equals ~stall_o.
- bubble_o  output  1  equals stall_o; zeroes ID/EX control.
- busy_o  output  1  at least one counter is non-zero.
- stall_count_o  output  CNT_W  saturating count of cycles with stall_o=1.

Behaviour:
- State: cnt[1..NUM_REGS-1] of LAT_W bits, plus stall_count. Asynchronous clear of all state when rst_i=0, including mid-operation.
- Reset output values: stall_o=0, pcwrite_o=1, ifidwrite_o=1, bubble_o=0, busy_o=0, stall_count_o=0.
- RAW condition: issue_valid_i & ((issue_uses_rs_i & rs!=0 & cnt[rs]!=0) | (issue_uses_rt_i & rt!=0 & cnt[rt]!=0)).
- WAW condition: issue_valid_i & issue_wr_i & rd!=0 & cnt[rd] > lat_eff.
  - lat_eff = min(issue_lat_i, MAX_LAT).
  - WAW prevents an older, slower result from overwriting a younger one.
- stall_o = (RAW | WAW) & ~flush_i. Combinational from registered counters and inputs; no latency.
- Accept = issue_valid_i & ~stall_o & ~flush_i & ~freeze_i.
- Per-register update each edge:
  - freeze_i=1: all counters hold. Accept is suppressed.
  - else, if Accept & issue_wr_i & rd==r & r!=0: cnt[r] <= lat_eff. New issue wins over decrement in the same cycle.
  - else, if cnt[r]!=0: cnt[r] <= cnt[r]-1.
- Latency 0: no entry is created, so no dependent stall (pure forwarding path).
- Latency 1: exactly one bubble for an immediately dependent instruction (classic load-use).
- Latency N: dependent instruction stalls N cycles, absent freeze.
- flush_i wins over stall. A killed instruction creates no entry; in-flight counters are unaffected.
- stall_count increments on each non-frozen cycle with stall_o=1 and saturates at all-ones (no wrap).
- busy_o = OR of all cnt[r]!=0, registered-state based.

Decomposition:
- Shared package (pipeline_pkg): REG_AW, MAX_LAT, LAT_W defaults; latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3.
- One natural sub-module: reg_countdown.
  - One LAT_W-bit load/decrement/hold counter with async active-low clear and a nonzero flag.
  - Instantiated NUM_REGS-1 times by generate.

Test Plan:
- Reset mid-operation: after load to r8 (lat 1), pull rst_i low mid-cycle -> busy_o=0, stall_o=0 and stall_count_o=0 immediately, without waiting for a clock edge.
- Load-use: issue lw r8 lat 1, next cycle issue add reading r8 -> stall_o=1 for exactly 1 cycle (pcwrite_o=0, bubble_o=1); add accepted next cycle; stall_count_o=1.
- Multi-cycle: mul r9 lat 3, then consumer of r9 -> 3 stall cycles; with freeze_i=1 for 2 of them, 5 cycles total and stall_count_o=3.
- WAW: mul r9 lat 3, next cycle add writing r9 lat 0 -> stall until cnt[r9]=0. Same-cycle reissue to a decrementing r10 loads the new latency (issue wins).
- Flush and r0: consumer of pending r8 with flush_i=1 -> stall_o=0 and no entry created; writes to r0 at lat 4 never set busy_o.
- Saturation: CNT_W=4, hold RAW stall 20 cycles -> stall_count_o stops at 15.
